// File: rtl/pat_det_sched.sv
// pat_det_sched: round-robin scheduler sharing one serial pattern-detector engine among NCH channels.
// Each job flushes the engine, shifts the word MSB-first, drains HIT_LAT cycles and reports the hit count.
module pat_det_sched #(
  parameter int NCH     = 4,
  parameter int WIDTH   = 8,
  parameter int HIT_LAT = 2,
  parameter int CW      = $clog2(WIDTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [NCH-1:0]           req_i,
  input  logic [NCH*WIDTH-1:0]     data_i,
  output logic [NCH-1:0]           gnt_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [$clog2(NCH)-1:0]   done_id_o,
  output logic [CW-1:0]            match_cnt_o,
  output logic                     det_rst_o,
  output logic                     det_valid_o,
  output logic                     det_d_o,
  input  logic                     det_hit_i
);
  localparam int IW = $clog2(NCH);
  localparam int MX = WIDTH > HIT_LAT ? WIDTH : HIT_LAT;
  localparam int TW = $clog2(MX) > 0 ? $clog2(MX) : 1;

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    FLUSH = 5'b00010,
    SHIFT = 5'b00100,
    DRAIN = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t state, nxt;
  logic [IW-1:0] last_gnt, id, win, idx;
  logic [WIDTH-1:0] sreg;
  logic [TW-1:0] cnt;
  logic [CW-1:0] hits, hits_nxt;
  logic found, run;

  // search starts one past the last grant and wraps
  always_comb begin
    win = last_gnt;
    idx = last_gnt;
    found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = IW'((int'(last_gnt) + i) % NCH);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = enable_i && found ? FLUSH : IDLE;
      FLUSH:   nxt = SHIFT;
      SHIFT:   nxt = cnt == TW'(WIDTH - 1) ? DRAIN : SHIFT;
      DRAIN:   nxt = cnt == TW'(HIT_LAT - 1) ? DONE : DRAIN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign run = state == SHIFT || state == DRAIN;
  assign hits_nxt = state == IDLE ? '0 :
                    (run && det_hit_i && hits != CW'(WIDTH)) ? hits + 1'b1 : hits;

  // outputs are registered from the next state so nothing reaches them combinationally
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      last_gnt    <= IW'(NCH - 1);
      id          <= '0;
      sreg        <= '0;
      cnt         <= '0;
      hits        <= '0;
      gnt_o       <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      done_id_o   <= '0;
      match_cnt_o <= '0;
      det_rst_o   <= 1'b1;
      det_valid_o <= 1'b0;
      det_d_o     <= 1'b0;
    end else begin
      state       <= nxt;
      cnt         <= run && nxt == state ? cnt + 1'b1 : '0;
      hits        <= hits_nxt;
      sreg        <= state == IDLE ? data_i[int'(win)*WIDTH +: WIDTH] :
                     nxt == SHIFT ? sreg << 1 : sreg;
      if (state == IDLE && nxt == FLUSH) begin
        id       <= win;
        last_gnt <= win;
      end
      gnt_o       <= nxt == IDLE ? '0 : state == IDLE ? NCH'(1) << win : gnt_o;
      busy_o      <= nxt != IDLE;
      done_o      <= nxt == DONE;
      det_rst_o   <= nxt == FLUSH;
      det_valid_o <= nxt == SHIFT;
      det_d_o     <= nxt == SHIFT && sreg[WIDTH-1];
      if (nxt == DONE) begin
        done_id_o   <= id;
        match_cnt_o <= hits_nxt;
      end
    end
  end
endmodule

// File: tb/tb_pat_det_sched.sv
// tb_pat_det_sched: directed bench with a scoreboard of expected {channel, count} per job.
// The engine model detects 11011 with overlap and a two-cycle hit latency.
module tb_pat_det_sched;
  localparam int NCH = 4;
  localparam int WIDTH = 8;
  localparam int HIT_LAT = 2;
  localparam int CW = $clog2(WIDTH + 1);

  logic clk = 1'b0;
  logic rst_i, enable_i, det_hit_i;
  logic [NCH-1:0] req_i, gnt_o;
  logic [NCH*WIDTH-1:0] data_i;
  logic busy_o, done_o, det_rst_o, det_valid_o, det_d_o;
  logic [$clog2(NCH)-1:0] done_id_o;
  logic [CW-1:0] match_cnt_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_id[$];
  int exp_cnt[$];

  pat_det_sched #(.NCH(NCH), .WIDTH(WIDTH), .HIT_LAT(HIT_LAT), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .req_i(req_i), .data_i(data_i),
    .gnt_o(gnt_o), .busy_o(busy_o), .done_o(done_o), .done_id_o(done_id_o),
    .match_cnt_o(match_cnt_o), .det_rst_o(det_rst_o), .det_valid_o(det_valid_o),
    .det_d_o(det_d_o), .det_hit_i(det_hit_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] hist;
  logic p1;
  always @(posedge clk) begin
    if (det_rst_o) begin
      hist <= '0;
      p1 <= 1'b0;
      det_hit_i <= 1'b0;
    end else begin
      if (det_valid_o) hist <= {hist[2:0], det_d_o};
      p1 <= det_valid_o && ({hist, det_d_o} == 5'b11011);
      det_hit_i <= p1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_o) begin
      if (exp_id.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got id %0d cnt %0d expected no done", done_id_o, match_cnt_o);
      end else begin
        chk("sb_done_id", int'(done_id_o), exp_id.pop_front());
        chk("sb_match_cnt", int'(match_cnt_o), exp_cnt.pop_front());
      end
    end
  end

  task automatic push(input int id, input int cnt);
    exp_id.push_back(id);
    exp_cnt.push_back(cnt);
  endtask

  task automatic wait_flush(output int t, output int n);
    t = -1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (det_rst_o && busy_o) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("flush_timeout", 0, 1);
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    t = -1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done_o) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tf, tp, td, n, seen, ok;
    logic [WIDTH-1:0] v;
    rst_i = 1'b0;
    enable_i = 1'b1;
    req_i = 4'b1111;
    data_i[0*WIDTH +: WIDTH] = 8'b1101_1000;
    data_i[1*WIDTH +: WIDTH] = 8'b1111_1111;
    data_i[2*WIDTH +: WIDTH] = 8'b1101_1011;
    data_i[3*WIDTH +: WIDTH] = 8'b0001_1011;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_done_id", int'(done_id_o), 0);
    chk("rst_match", int'(match_cnt_o), 0);
    chk("rst_det_rst", int'(det_rst_o), 1);
    chk("rst_det_valid", int'(det_valid_o), 0);
    chk("rst_det_d", int'(det_d_o), 0);

    // round-robin with all requests held
    push(0, 1); push(1, 0); push(2, 2); push(3, 1); push(0, 1);
    rst_i = 1'b1;
    tp = 0;
    for (int j = 0; j < 5; j++) begin
      wait_flush(tf, n);
      if (j == 0) chk("first_gnt_latency", n, 1);
      chk("rr_gnt", int'(gnt_o), 1 << (j % 4));
      if (j > 0) chk("rr_period", tf - tp, 13);
      tp = tf;
      wait_done(td);
      chk("rr_job_len", td - tf, 11);
      if (j == 4) req_i = '0;
    end

    // single job, serial bit order
    req_i = 4'b0100;
    push(2, 2);
    wait_flush(tf, n);
    chk("single_gnt", int'(gnt_o), 4);
    v = '0;
    ok = 1;
    for (int b = 0; b < WIDTH; b++) begin
      @(negedge clk);
      v = {v[WIDTH-2:0], det_d_o};
      if (!det_valid_o) ok = 0;
    end
    chk("single_d_seq", int'(v), 8'b1101_1011);
    chk("single_valid", ok, 1);
    @(negedge clk);
    chk("drain_valid", int'(det_valid_o), 0);
    wait_done(td);
    chk("single_done_lat", td - tf + 0, 11);
    req_i = '0;

    // flush isolation across consecutive jobs
    data_i[0*WIDTH +: WIDTH] = 8'b0000_1101;
    data_i[1*WIDTH +: WIDTH] = 8'b1000_0000;
    req_i = 4'b0011;
    push(0, 0); push(1, 0);
    wait_flush(tf, n);
    chk("iso_gnt0", int'(gnt_o), 1);
    wait_done(td);
    req_i[0] = 1'b0;
    wait_flush(tf, n);
    chk("iso_gnt1", int'(gnt_o), 2);
    wait_done(td);
    req_i = '0;

    // enable dropped mid-job
    data_i[0*WIDTH +: WIDTH] = 8'b1101_1000;
    data_i[1*WIDTH +: WIDTH] = 8'b1111_1111;
    req_i = 4'b0001;
    push(0, 1);
    wait_flush(tf, n);
    chk("en_gnt0", int'(gnt_o), 1);
    repeat (3) @(negedge clk);
    enable_i = 1'b0;
    req_i[1] = 1'b1;
    wait_done(td);
    chk("en_job_len", td - tf, 11);
    req_i[0] = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_o || gnt_o != '0) seen = 1;
    end
    chk("en_hold_off", seen, 0);
    push(1, 0);
    enable_i = 1'b1;
    wait_flush(tf, n);
    chk("en_gnt1", int'(gnt_o), 2);
    wait_done(td);
    req_i = '0;

    // reset in the middle of SHIFT
    data_i[2*WIDTH +: WIDTH] = 8'b1101_1011;
    req_i = 4'b0100;
    wait_flush(tf, n);
    chk("abort_gnt", int'(gnt_o), 4);
    repeat (5) @(negedge clk);
    chk("abort_in_shift", int'(det_valid_o), 1);
    rst_i = 1'b0;
    #1;
    chk("abort_gnt_clear", int'(gnt_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_det_rst", int'(det_rst_o), 1);
    req_i = 4'b1010;
    repeat (3) @(negedge clk);
    push(1, 0); push(3, 1);
    rst_i = 1'b1;
    wait_flush(tf, n);
    chk("post_abort_gnt1", int'(gnt_o), 2);
    wait_done(td);
    req_i[1] = 1'b0;
    wait_flush(tf, n);
    chk("post_abort_gnt3", int'(gnt_o), 8);
    wait_done(td);
    req_i = '0;
    repeat (5) @(negedge clk);
    chk("sb_empty", exp_id.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
